stp_frame_ctrl: RTL and testbench
=================================

# stp_frame_ctrl

Frame controller for the serial-to-parallel (STP) shift register on the MRAM test path driven by the STM32F411RE. It frames incoming serial bits using the MCU chip-select and generates the shift-register enable. It counts `BUS_WIDTH` shifts, captures the completed parallel word into a holding register, and presents it to the MRAM write side over a valid/ready handshake. It also detects aborted frames, gap timeouts and word overruns.

## Interface
- `BUS_WIDTH`, 3: word width; must equal the shift register width; legal range is 2 or more.
- `TIMEOUT_CYCLES`, 1024: allowed idle clock cycles between bits inside a word; 0 disables the timeout.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cs`  in  1  frame select from the MCU (already synchronised), active-high.
- `bit_valid`  in  1  one-cycle strobe; a serial bit is present on the shift register's `data_in` this cycle.
- `sr_data`  in  `BUS_WIDTH`  parallel output of the shift register.
- `sr_en`  out  1  shift enable to the shift register; combinational.
- `word_out`  out  `BUS_WIDTH`  captured word.
- `word_valid`  out  1  `word_out` is valid.
- `word_ready`  in  1  consumer accepts `word_out`.
- `busy`  out  1  a partial word is in progress (`bit_cnt != 0`).
- `overrun`  out  1  sticky; a completed word was dropped.
- `frame_err`  out  1  sticky; a partial word was aborted by `cs` falling or by timeout.
- `err_clr`  in  1  clears `overrun` and `frame_err`.

## Operation
- State machine has three states:
  - `IDLE`: entered at reset and whenever `cs`=0.
  - `COLLECT`: entered from `IDLE` when `cs`=1.
  - `CAPTURE`: lasts exactly 1 cycle.
- `sr_en = bit_valid & cs & (state != IDLE)`. Bits strobed in `IDLE` are ignored and not counted.
- `bit_cnt`, width `$clog2(BUS_WIDTH+1)`, increments on each `sr_en`.
- On the `sr_en` where `bit_cnt == BUS_WIDTH-1`: `bit_cnt` goes to 0 and the next state is `CAPTURE`.
- `CAPTURE` behaves like `COLLECT` for incoming bits, so a bit arriving in `CAPTURE` is shifted and counted. It then returns to `COLLECT`, or to `IDLE` if `cs`=0.
- Capture happens in `CAPTURE`:
  - If `!word_valid | word_ready`: `word_out <= sr_data` and `word_valid <= 1`.
  - Otherwise: the word is dropped and `overrun <= 1`. `word_out` keeps the older word.
  - The capture samples `sr_data` before any shift on the same edge.
- `word_valid` clears on `word_valid & word_ready`, unless a capture occurs in the same cycle, in which case it stays 1 with the new word.
- `cs` falling while `bit_cnt != 0`: `bit_cnt <= 0`, `frame_err <= 1`, next state `IDLE`.
- `cs` falling during `CAPTURE`: the capture still completes, with no error.
- Timeout:
  - The gap counter runs in `COLLECT` while `bit_cnt != 0` and `bit_valid`=0.
  - It reloads on every `sr_en`.
  - On reaching `TIMEOUT_CYCLES`: `bit_cnt <= 0` and `frame_err <= 1`.
- The stale shift-register contents need no clear: a new word always shifts all `BUS_WIDTH` positions.
- `err_clr` clears both sticky flags. If a set event occurs in the same cycle, the set wins.

## Timing
- Reset values:
  - `word_out` = 0, `word_valid` = 0, `overrun` = 0, `frame_err` = 0, `busy` = 0.
  - State is `IDLE`, so `sr_en` = 0.
  - `bit_cnt` = 0 and the gap counter = 0.
- Latency: if the last bit's `sr_en` is in cycle N, `CAPTURE` is cycle N+1 and `word_valid` is visible in N+2.
- Maximum sustained rate is one bit per cycle with no bubble.
- Reset asserted mid-word or mid-handshake: everything returns to the reset values immediately, and any pending word is lost.

## Structure
- Shared package `stp_ctrl_pkg`, holding:
  - the state encoding localparams `ST_IDLE`, `ST_COLLECT`, `ST_CAPTURE`;
  - a `clog2` helper function;
  - the default `TIMEOUT_CYCLES`.
- One sub-module, `stp_gap_timer`: a reloadable down-counter with inputs `reload` and `run`, output `expired`, and a `TIMEOUT_CYCLES` parameter (0 means never expires).
- The FSM, bit counter, holding register and flags live in the top of this block.

## Test plan
(Test bench uses `BUS_WIDTH`=3 with the real shift register attached.)
- Basic word: `cs`=1, bits 1,1,0 on consecutive cycles. Expect `sr_en` high 3 cycles, `word_out`=3'b011, `word_valid` 2 cycles after the third bit, `busy` low afterwards.
- Back-to-back words with `word_ready`=1: send 6 bits, one per cycle. Expect two captures, no bubble in `sr_en`, `overrun`=0.
- Overrun: `word_ready`=0, send two words. Expect `word_out` to keep the first word and `overrun`=1. Then pulse `err_clr`: `overrun`=0.
- Abort: send 2 bits, then drop `cs`. Expect `frame_err`=1, `busy`=0, no `word_valid`. The next 3 bits produce a correct word.
- Timeout (`TIMEOUT_CYCLES`=8): send 1 bit, then idle 8 cycles. Expect `frame_err`=1 and `bit_cnt` reset. Then send bits 1,0,0: `word_out`=3'b001.
- Reset mid-word and during pending `word_valid`: all outputs return to 0 asynchronously, and the first word after reset is correct.

Source files
------------

// File: rtl/stp_ctrl_pkg.sv
// Shared definitions for the STP frame controller: state encoding, default
// gap timeout and a constant ceil-log2 helper.
package stp_ctrl_pkg;

  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stp_gap_timer.sv
// Reloadable down-counter flagging an over-long gap between serial bits.
// A TIMEOUT_CYCLES of 0 disables expiry entirely.
module stp_gap_timer
  import stp_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W =
    (clog2(TIMEOUT_CYCLES + 1) > 0) ? clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = CNT_W'(TIMEOUT_CYCLES);
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the last allowed idle cycle so the abort lands after exactly TIMEOUT_CYCLES.
  assign expired = (TIMEOUT_CYCLES != 0) && run && !reload && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/stp_frame_ctrl.sv
// Frames serial bits into BUS_WIDTH words from the STP shift register and
// hands them to the MRAM write side over valid/ready, flagging errors.
module stp_frame_ctrl
  import stp_ctrl_pkg::*;
#(
  parameter int unsigned BUS_WIDTH      = 3,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic                 bit_valid,
  input  logic [BUS_WIDTH-1:0] sr_data,
  output logic                 sr_en,
  output logic [BUS_WIDTH-1:0] word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 busy,
  output logic                 overrun,
  output logic                 frame_err,
  input  logic                 err_clr
);

  localparam int unsigned CNT_W = clog2(BUS_WIDTH + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BUS_WIDTH-1:0] word_q, word_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q;
  logic                 last_bit, abort, gap_run, gap_expired, ovr_set;

  assign sr_en    = bit_valid & cs & (state_q != ST_IDLE);
  assign last_bit = sr_en && (bit_cnt_q == CNT_W'(BUS_WIDTH - 1));
  assign abort    = !cs && (bit_cnt_q != '0);
  assign gap_run  = (state_q == ST_COLLECT) && (bit_cnt_q != '0) && !bit_valid;

  stp_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .reload (sr_en),
    .run    (gap_run),
    .expired(gap_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // CAPTURE accepts bits like COLLECT, so words can stream with no bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cs) state_d = ST_COLLECT;
      end
      ST_COLLECT, ST_CAPTURE: begin
        if (!cs)           state_d = ST_IDLE;
        else if (last_bit) state_d = ST_CAPTURE;
        else               state_d = ST_COLLECT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    word_d    = word_q;
    valid_d   = valid_q;
    ovr_set   = 1'b0;

    if (abort || gap_expired || last_bit) begin
      bit_cnt_d = '0;
    end else if (sr_en) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end

    // sr_data here is the pre-shift value, i.e. the completed word.
    if (state_q == ST_CAPTURE) begin
      if (!valid_q || word_ready) begin
        word_d  = sr_data;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end

    overrun_d   = ovr_set ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
    frame_err_d = (abort || gap_expired) ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      busy_q      <= (bit_cnt_d != '0);
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_stp_frame_ctrl.sv
// Bench for stp_frame_ctrl with a behavioural shift register attached;
// expected words are queued as bits are driven and checked on handshake.
module tb_stp_frame_ctrl;

  localparam int unsigned W = 3;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         cs         = 1'b0;
  logic         bit_valid  = 1'b0;
  logic         din        = 1'b0;
  logic         word_ready = 1'b0;
  logic         err_clr    = 1'b0;
  logic [W-1:0] sr_q       = '0;
  logic         sr_en;
  logic [W-1:0] word_out;
  logic         word_valid, busy, overrun, frame_err;

  int           n_cmp     = 0;
  int           n_bad     = 0;
  int           sr_en_cnt = 0;
  int           c0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  stp_frame_ctrl #(
    .BUS_WIDTH     (W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (cs),
    .bit_valid (bit_valid),
    .sr_data   (sr_q),
    .sr_en     (sr_en),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  // Shift register: first bit ends up in the LSB, never reset.
  always @(posedge clk) if (sr_en) sr_q <= {din, sr_q[W-1:1]};

  always @(negedge clk) if (sr_en) sr_en_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(word_valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("word_out", 32'(word_out), 32'(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din       = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit push);
    if (push) exp_q.push_back(w);
    for (int i = 0; i < int'(W); i++) send_bit(w[i]);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    cs         = 1'b1;
    bit_valid  = 1'b1;
    word_ready = 1'b1;
    #12;
    check("rst_word_out",   32'(word_out),   32'd0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_overrun",    32'(overrun),    32'd0);
    check("rst_frame_err",  32'(frame_err),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_sr_en",      32'(sr_en),      32'd0);
    bit_valid = 1'b0;
    cs        = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Basic word with latency check.
    cs = 1'b1;
    tick();
    c0 = sr_en_cnt;
    send_word(3'b011, 1'b1);
    @(negedge clk);
    check("lat_n1_valid", 32'(word_valid), 32'd0);
    check("basic_sr_en", 32'(sr_en_cnt - c0), 32'd3);
    tick();
    @(negedge clk);
    check("lat_n2_valid", 32'(word_valid), 32'd1);
    check("basic_busy", 32'(busy), 32'd0);
    tick();

    // Back-to-back words, bit in CAPTURE must be counted.
    c0 = sr_en_cnt;
    send_word(3'b101, 1'b1);
    send_word(3'b110, 1'b1);
    drain("b2b_drain");
    check("b2b_sr_en", 32'(sr_en_cnt - c0), 32'd6);
    check("b2b_overrun", 32'(overrun), 32'd0);

    // Overrun: second word dropped, first held.
    word_ready = 1'b0;
    send_word(3'b100, 1'b1);
    send_word(3'b111, 1'b0);
    tick();
    tick();
    @(negedge clk);
    check("ovr_valid", 32'(word_valid), 32'd1);
    check("ovr_word_held", 32'(word_out), 32'b100);
    check("ovr_flag", 32'(overrun), 32'd1);
    tick();
    err_clr    = 1'b1;
    word_ready = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("ovr_cleared", 32'(overrun), 32'd0);
    check("ovr_valid_done", 32'(word_valid), 32'd0);
    check("ovr_no_frame_err", 32'(frame_err), 32'd0);
    check("ovr_drain", 32'(exp_q.size()), 32'd0);
    tick();

    // Abort by cs falling mid-word.
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    tick();
    cs = 1'b0;
    tick();
    @(negedge clk);
    check("abort_frame_err", 32'(frame_err), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_no_valid", 32'(word_valid), 32'd0);
    tick();
    cs = 1'b1;
    tick();
    send_word(3'b010, 1'b1);
    drain("abort_next_drain");
    check("abort_sticky", 32'(frame_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("abort_clr", 32'(frame_err), 32'd0);
    tick();

    // Gap timeout after exactly 8 idle cycles; err_clr in the same cycle loses.
    send_bit(1'b1);
    for (int i = 0; i < 7; i++) tick();
    err_clr = 1'b1;
    @(negedge clk);
    check("to_not_yet", 32'(frame_err), 32'd0);
    check("to_busy_pre", 32'(busy), 32'd1);
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("to_frame_err", 32'(frame_err), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    tick();
    send_word(3'b001, 1'b1);
    drain("to_next_drain");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Asynchronous reset with a pending word and a partial word.
    word_ready = 1'b0;
    send_word(3'b101, 1'b0);
    tick();
    tick();
    @(negedge clk);
    check("rst2_pending", 32'(word_valid), 32'd1);
    tick();
    send_bit(1'b1);
    check("rst2_busy_pre", 32'(busy), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst2_word_valid", 32'(word_valid), 32'd0);
    check("rst2_word_out",   32'(word_out),   32'd0);
    check("rst2_busy",       32'(busy),       32'd0);
    check("rst2_frame_err",  32'(frame_err),  32'd0);
    check("rst2_overrun",    32'(overrun),    32'd0);
    tick();
    rst_n      = 1'b1;
    word_ready = 1'b1;
    tick();
    send_word(3'b110, 1'b1);
    drain("rst2_next_drain");

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
